// File: rtl/fpga_log_pkg.sv
// Shared constants and helpers for the multi-channel FPGA log FIFO.
//   DROP_CNT_W : width of each per-channel drop counter
//   TS_W       : width of the capture timestamp
//   calc_ch_w  : channel ID width for a given channel count (minimum 1)
package fpga_log_pkg;

    localparam int unsigned DROP_CNT_W = 16;
    localparam int unsigned TS_W       = 32;

    function automatic int unsigned calc_ch_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fpga_log_ch_fifo.sv
// Single-channel synchronous FIFO with a fall-through head and an optional
// timestamp lane (FPGA_LOG_TIMESTAMP_EN).
//   clk, rst_n          : clock, async active-low reset
//   push_i/push_data_i  : write strobe and character (caller guarantees room)
//   push_ts_i           : timestamp stored with the character (feature only)
//   pop_i               : consume head entry (caller guarantees non-empty)
//   head_data_c_o       : head character, combinational from storage
//   head_ts_c_o         : head timestamp (feature only)
//   count_o             : registered occupancy
//   full_o              : registered occupancy == DEPTH
module fpga_log_ch_fifo
    import fpga_log_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
`ifdef FPGA_LOG_TIMESTAMP_EN
    input  logic [TS_W-1:0]   push_ts_i,
    output logic [TS_W-1:0]   head_ts_c_o,
`endif
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_c_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin : ptr_c
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
        else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
        full_d = (count_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin : ptr_q
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    // Push and pop at full hit the same slot; the head is read before the edge.
    always_ff @(posedge clk) begin : mem_data_q
        if (push_i) mem_data[wr_ptr_q] <= push_data_i;
    end

`ifdef FPGA_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] mem_ts [DEPTH];

    always_ff @(posedge clk) begin : mem_ts_q
        if (push_i) mem_ts[wr_ptr_q] <= push_ts_i;
    end

    assign head_ts_c_o = mem_ts[rd_ptr_q];
`endif

    assign head_data_c_o = mem_data[rd_ptr_q];
    assign count_o       = count_q;
    assign full_o        = full_q;

endmodule

// File: rtl/fpga_log_arb_fifo.sv
// Multi-channel log FIFO: NUM_CH per-channel FIFOs merged by a round-robin
// arbiter into one registered output stream tagged with the channel ID.
// Optional feature macro: FPGA_LOG_TIMESTAMP_EN (per-entry 32-bit cycle stamp).
//   core_clk, cptra_rst_b : clock, async active-low reset
//   wr_en, wr_data        : per-channel write strobes and characters
//   rd_en                 : pop output register
//   rd_valid/data/ch/ts   : output register
//   empty, full, prog_full: occupancy status
//   drop_cnt, clr_drop    : saturating per-channel drop counters and clear
module fpga_log_arb_fifo
    import fpga_log_pkg::*;
#(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned DATA_W           = 8,
    parameter int unsigned DEPTH            = 64,
    parameter int unsigned PROG_FULL_THRESH = 48,
    localparam int unsigned CH_W            = calc_ch_w(NUM_CH)
) (
    input  logic                         core_clk,
    input  logic                         cptra_rst_b,
    input  logic [NUM_CH-1:0]            wr_en,
    input  logic [NUM_CH*DATA_W-1:0]     wr_data,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic [CH_W-1:0]              rd_ch,
    output logic [TS_W-1:0]              rd_ts,
    output logic                         empty,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            prog_full,
    output logic [NUM_CH*DROP_CNT_W-1:0] drop_cnt,
    input  logic                         clr_drop
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count     [NUM_CH];
    logic [DATA_W-1:0] head_data [NUM_CH];
    logic [NUM_CH-1:0] ch_full, nonempty, push, pop, drop;

    logic [CH_W-1:0]   last_grant_q, last_grant_d, grant;
    logic              grant_vld, load;

    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [CH_W-1:0]   rd_ch_q, rd_ch_d;

`ifdef FPGA_LOG_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_cnt_q;
    logic [TS_W-1:0]   head_ts [NUM_CH];
    logic [TS_W-1:0]   rd_ts_q;
`endif

    // Round-robin search starting just after the last granted channel.
    always_comb begin : arb_c
        int unsigned idx;
        idx       = 0;
        grant     = last_grant_q;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_CH;
            if (!grant_vld && nonempty[CH_W'(idx)]) begin
                grant_vld = 1'b1;
                grant     = CH_W'(idx);
            end
        end
    end

    assign load = (!rd_valid_q || rd_en) && grant_vld;

    // Output register: refill on pop or when idle, drop valid when drained.
    always_comb begin : out_c
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_ch_d      = rd_ch_q;
        last_grant_d = last_grant_q;
        if (load) begin
            rd_valid_d   = 1'b1;
            rd_data_d    = head_data[grant];
            rd_ch_d      = grant;
            last_grant_d = grant;
        end else if (rd_en) begin
            rd_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin : out_q
        if (!cptra_rst_b) begin
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_ch_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_ch_q      <= rd_ch_d;
            last_grant_q <= last_grant_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DROP_CNT_W-1:0] drop_q, drop_d;

        assign nonempty[i]  = (count[i] != '0);
        assign pop[i]       = load && (grant == CH_W'(i));
        // A pop in the same cycle frees a slot for the incoming write.
        assign push[i]      = wr_en[i] && (!ch_full[i] || pop[i]);
        assign drop[i]      = wr_en[i] && !push[i];
        assign full[i]      = ch_full[i];
        assign prog_full[i] = (count[i] >= CNT_W'(PROG_FULL_THRESH));

        fpga_log_ch_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk           (core_clk),
            .rst_n         (cptra_rst_b),
            .push_i        (push[i]),
            .push_data_i   (wr_data[i*DATA_W +: DATA_W]),
`ifdef FPGA_LOG_TIMESTAMP_EN
            .push_ts_i     (ts_cnt_q),
            .head_ts_c_o   (head_ts[i]),
`endif
            .pop_i         (pop[i]),
            .head_data_c_o (head_data[i]),
            .count_o       (count[i]),
            .full_o        (ch_full[i])
        );

        // Saturating drop counter; clear has priority over a coincident drop.
        always_comb begin : drop_c
            drop_d = drop_q;
            if (clr_drop)                     drop_d = '0;
            else if (drop[i] && drop_q != '1) drop_d = drop_q + DROP_CNT_W'(1);
        end

        always_ff @(posedge core_clk or negedge cptra_rst_b) begin : drop_ff
            if (!cptra_rst_b) drop_q <= '0;
            else              drop_q <= drop_d;
        end

        assign drop_cnt[i*DROP_CNT_W +: DROP_CNT_W] = drop_q;
    end

`ifdef FPGA_LOG_TIMESTAMP_EN
    // Free-running cycle stamp and its output register.
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin : ts_q
        if (!cptra_rst_b) begin
            ts_cnt_q <= '0;
            rd_ts_q  <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
            if (load) rd_ts_q <= head_ts[grant];
        end
    end

    assign rd_ts = rd_ts_q;
`else
    assign rd_ts = '0;
`endif

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_ch    = rd_ch_q;
    assign empty    = !(|nonempty) && !rd_valid_q;

endmodule
